// File: rtl/bank_command_sequencer_pkg.sv
// bank_command_sequencer_pkg: command/state types, DRAM encodings and default timings for the bank sequencer
package bank_command_sequencer_pkg;
  localparam int DEF_COL_BITS = 10;
  localparam int DEF_T_RCD = 4;
  localparam int DEF_T_RP = 4;
  localparam int DEF_T_RAS = 10;
  localparam int DEF_T_RFC = 20;
  localparam int DEF_T_REFI = 200;
  localparam int TIMER_W = 16;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR, CMD_REF} cmd_e;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL, S_REF} state_e;
  function automatic logic [3:0] cmd_enc(input cmd_e c);
    return c == CMD_REF ? 4'b0001 :
           c == CMD_PRE ? 4'b0010 :
           c == CMD_ACT ? 4'b0011 :
           c == CMD_RD  ? 4'b0101 :
           c == CMD_WR  ? 4'b0100 : 4'b1111;
  endfunction
endpackage

// File: rtl/bank_command_sequencer_timing_counter.sv
// bank_timing_counter: loadable down-counter that stops at zero and flags it
module bank_timing_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/bank_command_sequencer.sv
// bank_command_sequencer: open-page per-bank DRAM command sequencer; each command state waits on its timer before asserting valid
module bank_command_sequencer
  import bank_command_sequencer_pkg::*;
#(
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RFC = DEF_T_RFC,
  parameter int T_REFI = DEF_T_REFI
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_is_write,
  input  logic [31:0] i_request_id,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [31:0] o_cmd_addr,
  output logic [31:0] o_cmd_data,
  output logic        o_cmd_cs,
  output logic        o_cmd_ras,
  output logic        o_cmd_cas,
  output logic        o_cmd_we,
  output logic [31:0] o_cmd_request_id,
  output logic [63:0] o_global_cycle,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_request_id
);
  localparam int RW = 32 - COL_BITS;
  state_e r_state, w_next;
  cmd_e w_cmd;
  logic [31:0] r_addr, r_data, r_id, r_resp_id;
  logic [RW-1:0] r_open_row;
  logic [15:0] r_ref_cnt;
  logic [63:0] r_cycle;
  logic [TIMER_W-1:0] w_wait_val;
  logic r_is_write, r_row_open, r_ref_pre, r_pend, r_resp_valid;
  logic w_wait_zero, w_ras_zero, w_fire, w_accept, w_hit, w_due, w_owned;
  assign w_hit = r_row_open && i_addr[31:COL_BITS] == r_open_row;
  assign w_due = r_ref_cnt == 16'(T_REFI - 1);
  assign o_ready = i_rst_n && r_state == S_IDLE && !r_pend && w_wait_zero;
  assign w_accept = i_valid && o_ready;
  assign w_cmd = !w_wait_zero ? CMD_NOP :
                 r_state == S_PRE ? (w_ras_zero ? CMD_PRE : CMD_NOP) :
                 r_state == S_ACT ? CMD_ACT :
                 r_state == S_COL ? (r_is_write ? CMD_WR : CMD_RD) :
                 r_state == S_REF ? CMD_REF : CMD_NOP;
  assign o_cmd_valid = w_cmd != CMD_NOP;
  assign w_fire = o_cmd_valid && i_cmd_ready;
  assign w_owned = o_cmd_valid && w_cmd != CMD_REF && !(w_cmd == CMD_PRE && r_ref_pre);
  assign {o_cmd_cs, o_cmd_ras, o_cmd_cas, o_cmd_we} = cmd_enc(w_cmd);
  assign o_cmd_addr = !w_owned && w_cmd != CMD_PRE ? '0 :
                      w_cmd == CMD_PRE && r_ref_pre ? {r_open_row, {COL_BITS{1'b0}}} : r_addr;
  assign o_cmd_data = w_cmd == CMD_WR ? r_data : '0;
  assign o_cmd_request_id = w_owned ? r_id : '0;
  assign o_global_cycle = r_cycle;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_request_id = r_resp_id;
  assign w_wait_val = r_state == S_PRE ? TIMER_W'(T_RP - 1) :
                      r_state == S_ACT ? TIMER_W'(T_RCD - 1) : TIMER_W'(T_RFC - 1);
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE)
      w_next = w_wait_zero && r_pend ? (r_row_open ? S_PRE : S_REF) :
               w_accept ? (w_hit ? S_COL : r_row_open ? S_PRE : S_ACT) : S_IDLE;
    else if (w_fire)
      w_next = r_state == S_PRE ? (r_ref_pre ? S_REF : S_ACT) :
               r_state == S_ACT ? S_COL : S_IDLE;
  end
  bank_timing_counter #(.W(TIMER_W)) u_wait (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load(w_fire && r_state != S_COL), .i_value(w_wait_val), .o_zero(w_wait_zero)
  );
  bank_timing_counter #(.W(TIMER_W)) u_ras (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load(w_fire && r_state == S_ACT), .i_value(TIMER_W'(T_RAS - 1)), .o_zero(w_ras_zero)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cycle <= '0;
      r_ref_cnt <= '0;
      r_pend <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_id <= '0;
      r_is_write <= 1'b0;
      r_ref_pre <= 1'b0;
      r_row_open <= 1'b0;
      r_open_row <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id <= '0;
    end else begin
      r_state <= w_next;
      r_cycle <= r_cycle + 64'd1;
      r_ref_cnt <= w_due ? '0 : r_ref_cnt + 16'd1;
      r_pend <= w_due || (r_pend && !(w_fire && r_state == S_REF));
      if (w_accept) begin
        r_addr <= i_addr;
        r_data <= i_data;
        r_id <= i_request_id;
        r_is_write <= i_is_write;
      end
      if (r_state == S_IDLE) r_ref_pre <= r_pend;
      if (w_fire && r_state == S_PRE) r_row_open <= 1'b0;
      if (w_fire && r_state == S_ACT) begin
        r_row_open <= 1'b1;
        r_open_row <= r_addr[31:COL_BITS];
      end
      r_resp_valid <= w_fire && r_state == S_COL;
      r_resp_id <= w_fire && r_state == S_COL ? r_id : '0;
    end
endmodule

// File: doc/bank_command_sequencer.md
Name: bank_command_sequencer

Overview:
Per-bank DRAM command sequencer. It accepts read/write requests for one (rank, bankgroup, bank) and converts each into ACTIVATE/PRECHARGE/READ/WRITE/REFRESH commands, using an open-page policy and enforcing tRCD/tRP/tRAS/tRFC and periodic refresh. It sits directly upstream of the per-bank performance statistics logger and drives that logger's req_fire, addr, data, cs/ras/cas/we, globalCycle and request_id inputs.

Parameters:
COL_BITS, 10, low address bits forming the column; row = addr[31:COL_BITS]
T_RCD, 4, minimum cycles from ACTIVATE fire to column command valid
T_RP, 4, minimum cycles from PRECHARGE fire to ACTIVATE/REFRESH valid
T_RAS, 10, minimum cycles from ACTIVATE fire to PRECHARGE valid
T_RFC, 20, minimum cycles from REFRESH fire to any next command valid
T_REFI, 200, refresh interval in cycles

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_addr  in  32  request byte address
in_data  in  32  write data
in_is_write  in  1  1 = write, 0 = read
in_request_id  in  32  request tag
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted; cmd_fire = cmd_valid && cmd_ready (drives logger req_fire)
cmd_addr  out  32  command address
cmd_data  out  32  write data (0 for non-WRITE commands)
cmd_cs, cmd_ras, cmd_cas, cmd_we  out  1 each  command encoding
cmd_request_id  out  32  tag of the owning request (0 for REFRESH)
global_cycle  out  64  free-running cycle count
resp_valid  out  1  one-cycle pulse: column command completed
resp_request_id  out  32  tag for resp_valid

Behaviour:
- Reset: state IDLE; in_ready=0 while reset is asserted; cmd_valid=0; resp_valid=0; global_cycle=0; row_open=0; refresh counter=0; refresh_pending=0. Idle encoding: cs,ras,cas,we = 1,1,1,1. All data/id outputs = 0.
- Encodings (cs,ras,cas,we): REFRESH 0001, PRECHARGE 0010, ACTIVATE 0011, READ 0101, WRITE 0100.
- global_cycle increments by 1 every cycle and wraps at 2^64.
- Refresh counter increments every cycle. When it reaches T_REFI-1 it sets refresh_pending and restarts at 0. A pending flag that is already set stays set; it is never counted twice.
- in_ready=1 only in IDLE with refresh_pending=0. The request fields are latched on acceptance.
- IDLE:
  - refresh_pending with row_open → PRE; with row closed → REF.
  - Otherwise, on acceptance: row hit → COL; row miss with row_open → PRE; row closed → ACT.
  - The command is valid in the cycle after acceptance.
- PRE:
  - cmd_valid is held until the tRAS timer (loaded at ACT fire) has expired.
  - On fire: row_open=0, load T_RP timer, go to WAIT_RP.
  - WAIT_RP exits to REF if the precharge was refresh-driven, otherwise to ACT.
- ACT: on fire, open_row=row, row_open=1, load T_RCD and T_RAS timers, go to WAIT_RCD, then COL.
- COL: issues READ or WRITE. On fire, resp_valid pulses in the next cycle with the latched id, then the block returns to IDLE.
- REF: on fire, clear refresh_pending, load T_RFC timer, go to WAIT_RFC, then IDLE.
- Timers: loaded with T-1 on fire. The next command is valid in the cycle the timer reaches 0, i.e. valid at exactly fire_cycle+T when cmd_ready=1.
- Backpressure: while cmd_valid=1 && cmd_ready=0, all cmd_* outputs are held stable. Timing counts from the fire, not from when the command became valid.
- cmd_addr is the latched request address for PRE/ACT/COL, and {open_row, COL_BITS'0} for a refresh-driven PRE. REF uses 0.
- A refresh that becomes pending during a request does not abort it; the refresh is served in the next IDLE.
- Reset asserted mid-operation immediately returns every output to its reset value and closes the row.

Decomposition:
- Shared package holds: the command enum (NOP/ACT/PRE/RD/WR/REF), the cs/ras/cas/we encoding function, the state enum, and default timing constants.
- One natural sub-module: bank_timing_counter, a loadable down-counter with a zero flag, instantiated for the tRCD/tRP/tRFC wait timer and for the tRAS timer.

Test Plan:
- Closed-bank read, cmd_ready=1: accept addr 0x00001400, id 7 at cycle A → ACT (0011, addr 0x1400) valid at A+1; READ (0101) valid at A+5; resp_valid with id 7 at A+6.
- Row hit: then read 0x00001408, id 8 → READ valid the cycle after acceptance, no ACT issued.
- Row miss write: 0x00002400, id 9, data 0xDEADBEEF → PRE not valid before ACT_fire+10; ACT at PRE_fire+4; WRITE with cmd_data 0xDEADBEEF at ACT_fire+4.
- Backpressure: hold cmd_ready=0 for 6 cycles during ACT → outputs stable; READ valid at actual fire+4.
- Refresh with row 5 open at global_cycle 199: in_ready drops; PRE, then REF at PRE_fire+4 with id 0; in_ready returns at REF_fire+20; next access to row 5 issues ACT.
- Reset pulse during WAIT_RCD → cmd_valid=0, resp_valid=0, global_cycle=0; after release, the next request to the same row issues ACT.
